// File: rtl/uart_tx_fifo_if.sv
// Byte-producer side of the UART transmitter: write port,
// FIFO status and the serial pin.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_BITS-1:0] din;
    logic                 wr_en;
    logic                 full;
    logic [LW-1:0]        level;
    logic                 busy;
    logic                 txd;

    modport master (
        output din, wr_en,
        input  full, level, busy, txd
    );

    modport slave (
        input  din, wr_en,
        output full, level, busy, txd
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO: start, LSB-first
// data, optional parity and stop bits, back-to-back framing.
module uart_tx_fifo #(
    parameter int CLK_DIV    = 434,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    uart_tx_fifo_if.slave bus
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(DATA_BITS);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("CLK_DIV must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
        $error("DATA_BITS must be 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
        $error("PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2, >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 txd_q, txd_d;
    logic [PW-1:0]        wptr_q, wptr_d;
    logic [PW-1:0]        rptr_q, rptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 full_q, full_d;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

    logic                 tick, pop, push;
    logic [DATA_BITS-1:0] head;

    assign head = mem[rptr_q];
    assign tick = (cnt_q == CW'(CLK_DIV - 1));
    assign push = bus.wr_en && !full_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        if (state_q != S_IDLE) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                txd_d = 1'b1;
                pop   = (level_q != '0);
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                            stop_d  = 1'b0;
                        end
                    end else begin
                        bit_d = bit_q + BW'(1);
                        txd_d = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                    stop_d  = 1'b0;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (stop_q == 1'(STOP_BITS - 1)) begin
                        if (level_q != '0) begin
                            pop = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase
        // Parity is fixed from the word as popped, not the live FIFO.
        if (pop) begin
            state_d = S_START;
            cnt_d   = '0;
            shift_d = head;
            par_d   = (^head) ^ (PARITY == 1);
            txd_d   = 1'b0;
        end
    end

    always_comb begin
        wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
        level_d = level_q + LW'(push) - LW'(pop);
        full_d  = (level_d == LW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            full_q  <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= bus.din;
        end
    end

    assign bus.full  = full_q;
    assign bus.level = level_q;
    assign bus.busy  = (state_q != S_IDLE) || (level_q != '0);
    assign bus.txd   = txd_q;
endmodule
